// File: rtl/henon_prng_engine.sv
// henon_prng_engine
// Fixed-point Henon map generator perturbed by a stream of pixels:
//   x' = 1 - a*x^2 + y + p,  y' = b*x
// One shared signed multiplier is reused over the SQ/AX/BX steps, so each
// iteration takes four cycles plus the WARM/ACCEPT cycle that feeds it.
// Optional build macro: HENON_DIVERGE_DET_EN. When it is defined, an iterate
// with |x| >= 2.0 is replaced by the seed state and the sticky `diverged`
// flag is raised. Without the macro, `diverged` is tied low.
module henon_prng_engine #(
  parameter int W         = 32,
  parameter int FRAC      = 29,
  parameter int SEED_W    = 16,
  parameter int PIX_W     = 8,
  parameter int PIX_SHIFT = 21,
  parameter int NPIX_W    = 16,
  parameter int WARMUP    = 4,
  parameter logic [W-1:0] A_COEF = 32'h2CCCCCCD,
  parameter logic [W-1:0] B_COEF = 32'h0999999A
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stream,
  input  logic [SEED_W-1:0] seed,
  input  logic [NPIX_W-1:0] n_pixels,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              pix_valid,
  output logic              pix_ready,
  output logic [W-1:0]      out_x,
  output logic [W-1:0]      out_y,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              diverged
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WARM   = 3'd1,
    S_ACCEPT = 3'd2,
    S_SQ     = 3'd3,
    S_AX     = 3'd4,
    S_BX     = 3'd5,
    S_UPD    = 3'd6,
    S_FIN    = 3'd7
  } state_e;

  localparam logic [W-1:0]   SAT_MAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]   SAT_MIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic [W+1:0]   ONE_E    = {{(W+1){1'b0}}, 1'b1} << FRAC;
  localparam logic [31:0]    WARMUP_L = 32'(WARMUP);
  localparam logic [NPIX_W-1:0] NPIX_ONE = {{(NPIX_W-1){1'b0}}, 1'b1};
`ifdef HENON_DIVERGE_DET_EN
  localparam logic signed [W-1:0] TWO     = {{(W-1){1'b0}}, 1'b1} << (FRAC + 1);
  localparam logic signed [W-1:0] NEG_TWO = ~TWO + {{(W-1){1'b0}}, 1'b1};
`endif

  // Keep bits [FRAC+W-1:FRAC] of a product; clamp when the dropped high bits
  // are not a pure sign extension of the kept result.
  function automatic logic [W-1:0] sat_prod(input logic [2*W-FRAC-1:0] hi);
    logic [W-FRAC:0] guard;
    guard = hi[2*W-FRAC-1:W-1];
    if ((&guard) || (~|guard)) begin
      sat_prod = hi[W-1:0];
    end else if (hi[2*W-FRAC-1]) begin
      sat_prod = SAT_MIN;
    end else begin
      sat_prod = SAT_MAX;
    end
  endfunction

  // Clamp a W+2 bit sum back to the W-bit signed range.
  function automatic logic [W-1:0] sat_sum(input logic [W+1:0] s);
    logic [2:0] guard;
    guard = s[W+1:W-1];
    if ((&guard) || (~|guard)) begin
      sat_sum = s[W-1:0];
    end else if (s[W+1]) begin
      sat_sum = SAT_MIN;
    end else begin
      sat_sum = SAT_MAX;
    end
  endfunction

  state_e              state_q, state_d;
  logic [W-1:0]        x_q, x_d, y_q, y_d, p_q, p_d, t_q, t_d, u_q, u_d;
  logic [NPIX_W-1:0]   npix_q, npix_d, pix_cnt_q, pix_cnt_d;
  logic [31:0]         warm_cnt_q, warm_cnt_d;
  logic                stream_q, stream_d, in_warm_q, in_warm_d;
  logic [W-1:0]        out_x_q, out_x_d, out_y_q, out_y_d;
  logic                out_valid_q, out_valid_d, busy_q, busy_d;
  logic                done_q, done_d, diverged_q, diverged_d;
`ifdef HENON_DIVERGE_DET_EN
  logic [W-1:0]        x0_q, x0_d;
`endif

  logic [W-1:0]          x0_s, pix_ext_s;
  logic signed [W-1:0]   mul_a_s, mul_b_s;
  logic signed [2*W-1:0] prod_s;
  logic                  prod_unused_s;
  logic [W+1:0]          sum_s;
  logic [W-1:0]          x_calc_s, x_upd_s, y_upd_s, prod_sat_s;
  logic                  div_hit_s;

  assign x0_s      = {{(W-SEED_W){1'b0}}, seed} << (FRAC - SEED_W);
  assign pix_ext_s = {{(W-PIX_W){1'b0}}, pix_data} << PIX_SHIFT;

  // Route the shared multiplier operands according to the iteration step.
  always_comb begin
    mul_a_s = x_q;
    mul_b_s = x_q;
    case (state_q)
      S_AX: begin
        mul_a_s = A_COEF;
        mul_b_s = t_q;
      end
      S_BX: begin
        mul_a_s = B_COEF;
        mul_b_s = x_q;
      end
      default: begin
        mul_a_s = x_q;
        mul_b_s = x_q;
      end
    endcase
  end

  assign prod_s        = $signed({{W{mul_a_s[W-1]}}, mul_a_s}) * $signed({{W{mul_b_s[W-1]}}, mul_b_s});
  assign prod_unused_s = ^prod_s[FRAC-1:0];
  assign prod_sat_s    = sat_prod(prod_s[2*W-1:FRAC]);

  // Form the next (x, y) pair, including the optional escape reload.
  always_comb begin
    sum_s     = ONE_E - {{2{t_q[W-1]}}, t_q} + {{2{y_q[W-1]}}, y_q} + {{2{p_q[W-1]}}, p_q};
    x_calc_s  = sat_sum(sum_s);
    x_upd_s   = x_calc_s;
    y_upd_s   = u_q;
    div_hit_s = 1'b0;
`ifdef HENON_DIVERGE_DET_EN
    if (($signed(x_calc_s) >= TWO) || ($signed(x_calc_s) <= NEG_TWO)) begin
      x_upd_s   = x0_q;
      y_upd_s   = {W{1'b0}};
      div_hit_s = 1'b1;
    end else begin
      div_hit_s = 1'b0;
    end
`endif
  end

  // Next-state and next-output logic for the iteration sequencer.
  always_comb begin
    logic emit;
    logic fin;
    emit        = 1'b0;
    fin         = 1'b0;
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    p_d         = p_q;
    t_d         = t_q;
    u_d         = u_q;
    npix_d      = npix_q;
    pix_cnt_d   = pix_cnt_q;
    warm_cnt_d  = warm_cnt_q;
    stream_d    = stream_q;
    in_warm_d   = in_warm_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;
    done_d      = done_q;
    diverged_d  = diverged_q;
`ifdef HENON_DIVERGE_DET_EN
    x0_d        = x0_q;
`endif
    case (state_q)
      S_IDLE, S_FIN: begin
        if (start) begin
          x_d        = x0_s;
          y_d        = {W{1'b0}};
          p_d        = {W{1'b0}};
          npix_d     = n_pixels;
          stream_d   = stream;
          pix_cnt_d  = {NPIX_W{1'b0}};
          warm_cnt_d = 32'd0;
          done_d     = 1'b0;
          busy_d     = 1'b1;
          diverged_d = 1'b0;
`ifdef HENON_DIVERGE_DET_EN
          x0_d       = x0_s;
`endif
          if (WARMUP_L != 32'd0) begin
            in_warm_d = 1'b1;
            state_d   = S_WARM;
          end else if (n_pixels == {NPIX_W{1'b0}}) begin
            // Nothing to iterate: report the seed state straight away.
            in_warm_d   = 1'b0;
            state_d     = S_FIN;
            out_x_d     = x0_s;
            out_y_d     = {W{1'b0}};
            out_valid_d = 1'b1;
            done_d      = 1'b1;
            busy_d      = 1'b0;
          end else begin
            in_warm_d = 1'b0;
            state_d   = S_ACCEPT;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_WARM: begin
        p_d     = {W{1'b0}};
        state_d = S_SQ;
      end
      S_ACCEPT: begin
        if (pix_valid) begin
          p_d     = pix_ext_s;
          state_d = S_SQ;
        end else begin
          state_d = S_ACCEPT;
        end
      end
      S_SQ: begin
        t_d     = prod_sat_s;
        state_d = S_AX;
      end
      S_AX: begin
        t_d     = prod_sat_s;
        state_d = S_BX;
      end
      S_BX: begin
        u_d     = prod_sat_s;
        state_d = S_UPD;
      end
      S_UPD: begin
        x_d        = x_upd_s;
        y_d        = y_upd_s;
        diverged_d = diverged_q | div_hit_s;
        if (in_warm_q) begin
          warm_cnt_d = warm_cnt_q + 32'd1;
          if ((warm_cnt_q + 32'd1) == WARMUP_L) begin
            in_warm_d = 1'b0;
            if (npix_q == {NPIX_W{1'b0}}) begin
              fin  = 1'b1;
              emit = 1'b1;
            end else begin
              state_d = S_ACCEPT;
            end
          end else begin
            state_d = S_WARM;
          end
        end else begin
          pix_cnt_d = pix_cnt_q + NPIX_ONE;
          if ((pix_cnt_q + NPIX_ONE) == npix_q) begin
            fin  = 1'b1;
            emit = 1'b1;
          end else begin
            emit    = stream_q;
            state_d = S_ACCEPT;
          end
        end
        if (emit) begin
          out_x_d     = x_upd_s;
          out_y_d     = y_upd_s;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
        if (fin) begin
          state_d = S_FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          busy_d  = busy_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Register all state and outputs; reset abandons any run in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      x_q         <= {W{1'b0}};
      y_q         <= {W{1'b0}};
      p_q         <= {W{1'b0}};
      t_q         <= {W{1'b0}};
      u_q         <= {W{1'b0}};
      npix_q      <= {NPIX_W{1'b0}};
      pix_cnt_q   <= {NPIX_W{1'b0}};
      warm_cnt_q  <= 32'd0;
      stream_q    <= 1'b0;
      in_warm_q   <= 1'b0;
      out_x_q     <= {W{1'b0}};
      out_y_q     <= {W{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      diverged_q  <= 1'b0;
`ifdef HENON_DIVERGE_DET_EN
      x0_q        <= {W{1'b0}};
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      p_q         <= p_d;
      t_q         <= t_d;
      u_q         <= u_d;
      npix_q      <= npix_d;
      pix_cnt_q   <= pix_cnt_d;
      warm_cnt_q  <= warm_cnt_d;
      stream_q    <= stream_d;
      in_warm_q   <= in_warm_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      diverged_q  <= diverged_d;
`ifdef HENON_DIVERGE_DET_EN
      x0_q        <= x0_d;
`endif
    end
  end

  assign pix_ready = (state_q == S_ACCEPT);
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign diverged  = diverged_q;

endmodule
